guess_entry_ctrl: RTL and testbench
===================================

// Module: guess_entry_ctrl
// PURPOSE
//  Sequences keypad entry of one guess for the number-guessing game.
//  - Consumes key events from keypad_scan.
//  - Builds a DIGITS-wide BCD entry buffer that drives the 7-segment path, with backspace.
//  - Commits the guess to the game FSM on '*' using a valid/ack handshake.
//  - Abandons idle entries after a timeout.
// PARAMETERS
//  DIGITS       2         number of decimal digits in the entry buffer
//  VAL_W        7         width of binary guess_val; must hold 10^DIGITS-1
//  TIMEOUT_CYC  50000000  idle cycles in ENTRY before auto-clear
//  CNT_W        26        width of the timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk         in   1           system clock
//  rst         in   1           asynchronous reset, active-low
//  scan_code   in   12          one-hot key: [9:0] = digits 0-9, [10] = '*', [11] = '#'
//  scan_valid  in   1           high while a key is held
//  guess_ack   in   1           game FSM accepted guess_val
//  clear_req   in   1           game FSM requests abort/clear (new round)
//  digit_bcd   out  4*DIGITS    BCD buffer; [3:0] = least significant digit
//  digit_cnt   out  2           digits currently entered, 0..DIGITS
//  guess_val   out  VAL_W       binary value of the committed guess
//  guess_valid out  1           committed guess pending; held until ack
//  entry_busy  out  1           high in ENTRY or COMMIT
//  timeout     out  1           one-cycle pulse on auto-clear
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; timer 0; prev scan_valid 0.
//  Key event:
//  - Cycle N has a registered scan_valid rising edge AND scan_code has exactly one bit set.
//  - Zero or multi-hot codes are dropped. Holding a key produces exactly one event.
//  Effect latency: buffer, cnt and state changes are visible at N+1.
//  States:
//  - IDLE:  digit -> load at LSD, cnt=1, go to ENTRY. '*' and '#' are ignored.
//  - ENTRY:
//    - digit: if cnt<DIGITS, shift buffer left 4 bits, insert at LSD, cnt++.
//      If cnt==DIGITS the digit is dropped and the buffer is unchanged.
//    - '#': shift right 4 bits (MSD <= 0), cnt--. If cnt reaches 0, go to IDLE.
//    - '*': guess_val = binary(digit_bcd), guess_valid=1, go to COMMIT.
//    - Any accepted or dropped key event reloads the timer to 0.
//    - Timer reaches TIMEOUT_CYC-1 with no event: clear buffer, cnt=0, timeout=1 for one cycle, go to IDLE.
//  - COMMIT:
//    - guess_val and digit_bcd are frozen. All key events are ignored.
//    - guess_ack=1: at next cycle guess_valid=0, buffer=0, cnt=0, go to IDLE.
//  guess_ack outside COMMIT is ignored.
//  clear_req has top priority in every state. Next cycle: IDLE, buffer/cnt/guess_valid/timer = 0, no timeout pulse.
//  Simultaneous events:
//  - clear_req with a key event or guess_ack: clear wins and the key is discarded.
//  - Timeout expiry with a key event in the same cycle: the key wins and the timer reloads.
//  Conversion: iterative Horner, val = val*10 + d, computed with (v<<3)+(v<<1).
//  - Combinational across DIGITS and registered once. No ack-before-valid path.
//  entry_busy = (state != IDLE). It is registered and follows the state.
// STRUCTURE
//  game_defs.vh (shared include):
//  - KEY_STAR=10, KEY_HASH=11.
//  - State encodings S_IDLE=2'b00, S_ENTRY=2'b01, S_COMMIT=2'b10.
//  Sub-module key_event_detect:
//  - Registers scan_valid and detects the rising edge.
//  - Checks one-hot and encodes to key_idx[3:0] plus key_evt.
//  - Reused by other keypad consumers.
//  The FSM, buffer, timer and conversion stay in guess_entry_ctrl.
// TESTING
//  1. Keys 4,2,'*' -> digit_bcd=8'h42, cnt=2, then guess_valid=1 with guess_val=42 held until ack; ack -> IDLE, all 0 next cycle.
//  2. Keys 7,3,9 -> 9 dropped, bcd=8'h73. '#' -> bcd=8'h07, cnt=1. '#' -> IDLE, cnt=0. '*' in IDLE -> no guess_valid.
//  3. Hold '5' for 1000 cycles -> exactly one event. scan_code=12'h003 with valid -> no change.
//  4. Enter 6 then idle TIMEOUT_CYC cycles (set to 16 in bench) -> timeout pulse exactly once, bcd=0, IDLE.
//     Key at cycle 15 -> no timeout.
//  5. In COMMIT: press '1' -> ignored. Assert clear_req and guess_ack together -> IDLE, guess_valid=0.
//  6. Drop rst mid-ENTRY (bcd=8'h09) asynchronously -> all outputs 0 immediately.
//     Release -> IDLE, the next digit is accepted normally.

Source files
------------

// File: rtl/guess_entry_ctrl_pkg.sv
// Shared constants for the keypad guess-entry path: key indices and FSM encodings.
package guess_entry_ctrl_pkg;

    localparam int unsigned KEY_W = 12;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ENTRY  = 2'b01;
    localparam logic [1:0] S_COMMIT = 2'b10;

endpackage

// File: rtl/key_event_detect.sv
// Turns a held one-hot keypad code into a single-cycle key event with a 4-bit key index.
module key_event_detect
    import guess_entry_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] scan_code,
    input  logic             scan_valid,
    output logic [3:0]       key_idx,
    output logic             key_evt
);

    logic valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= scan_valid;
        end
    end

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < KEY_W; i++) begin
            if (scan_code[i]) begin
                key_idx = 4'(i);
            end
        end
    end

    // Only the first cycle of a press counts, and only for a clean one-hot code.
    assign key_evt = scan_valid && !valid_q && $onehot(scan_code);

endmodule

// File: rtl/guess_entry_ctrl.sv
// Keypad guess entry: BCD buffer with backspace, '*' commit via valid/ack, idle timeout.
module guess_entry_ctrl
    import guess_entry_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned VAL_W       = 7,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_W-1:0]      scan_code,
    input  logic                  scan_valid,
    input  logic                  guess_ack,
    input  logic                  clear_req,
    output logic [4*DIGITS-1:0]   digit_bcd,
    output logic [1:0]            digit_cnt,
    output logic [VAL_W-1:0]      guess_val,
    output logic                  guess_valid,
    output logic                  entry_busy,
    output logic                  timeout
);

    localparam logic [1:0]       DIG_MAX = 2'(DIGITS);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [3:0]          key_idx;
    logic                key_evt;
    logic                is_digit;

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] buf_q, buf_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [VAL_W-1:0]    val_q, val_d;
    logic                valid_q, valid_d;
    logic                busy_q;
    logic                tout_q, tout_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [VAL_W-1:0]    conv;

    key_event_detect u_key_event_detect (
        .clk        (clk),
        .rst        (rst),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .key_idx    (key_idx),
        .key_evt    (key_evt)
    );

    assign is_digit = (key_idx <= KEY_DIGIT_MAX);

    // Horner over the BCD buffer, MSD first; x10 as (v<<3)+(v<<1).
    always_comb begin
        conv = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            conv = (conv << 3) + (conv << 1) + VAL_W'(buf_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        valid_d = valid_q;
        timer_d = timer_q;
        tout_d  = 1'b0;
        if (clear_req) begin
            state_d = S_IDLE;
            buf_d   = '0;
            cnt_d   = 2'd0;
            val_d   = '0;
            valid_d = 1'b0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_evt && is_digit) begin
                        buf_d   = {{(4*DIGITS-4){1'b0}}, key_idx};
                        cnt_d   = 2'd1;
                        timer_d = '0;
                        state_d = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (key_evt) begin
                        timer_d = '0;
                        if (is_digit) begin
                            if (cnt_q < DIG_MAX) begin
                                buf_d = {buf_q[4*DIGITS-5:0], key_idx};
                                cnt_d = cnt_q + 2'd1;
                            end
                        end else if (key_idx == KEY_HASH) begin
                            buf_d = {4'h0, buf_q[4*DIGITS-1:4]};
                            cnt_d = cnt_q - 2'd1;
                            if (cnt_q == 2'd1) begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            val_d   = conv;
                            valid_d = 1'b1;
                            state_d = S_COMMIT;
                        end
                    end else if (timer_q == TO_LAST) begin
                        buf_d   = '0;
                        cnt_d   = 2'd0;
                        timer_d = '0;
                        tout_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (guess_ack) begin
                        buf_d   = '0;
                        cnt_d   = 2'd0;
                        val_d   = '0;
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= 2'd0;
            val_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != S_IDLE);
            tout_q  <= tout_d;
            timer_q <= timer_d;
        end
    end

    assign digit_bcd   = buf_q;
    assign digit_cnt   = cnt_q;
    assign guess_val   = val_q;
    assign guess_valid = valid_q;
    assign entry_busy  = busy_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Bench for guess_entry_ctrl: directed scenarios plus random keys against a digit-list model.
module tb_guess_entry_ctrl;

    localparam int DIGITS = 2;
    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] scan_code = '0;
    logic        scan_valid = 1'b0;
    logic        guess_ack = 1'b0;
    logic        clear_req = 1'b0;
    logic [7:0]  digit_bcd;
    logic [1:0]  digit_cnt;
    logic [6:0]  guess_val;
    logic        guess_valid;
    logic        entry_busy;
    logic        timeout;

    int checks = 0;
    int passes = 0;

    guess_entry_ctrl #(
        .DIGITS      (2),
        .VAL_W       (7),
        .TIMEOUT_CYC (TO_CYC),
        .CNT_W       (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .guess_ack   (guess_ack),
        .clear_req   (clear_req),
        .digit_bcd   (digit_bcd),
        .digit_cnt   (digit_cnt),
        .guess_val   (guess_val),
        .guess_valid (guess_valid),
        .entry_busy  (entry_busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Reference: the entered guess is a list of decimal digits, MSD first.
    int mq[$];
    bit m_commit = 0;
    int m_idle = 0;
    int m_gval = 0;
    bit m_gvalid = 0;
    bit m_prev = 0;
    bit m_tout = 0;
    bit m_evt;
    int m_k;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_commit = 0; m_idle = 0; m_gval = 0; m_gvalid = 0; m_prev = 0; m_tout = 0;
        end else begin
            m_evt = scan_valid && !m_prev && ($countones(scan_code) == 1);
            m_k = 0;
            for (int i = 0; i < 12; i++) if (scan_code[i]) m_k = i;
            m_prev = scan_valid;
            m_tout = 0;
            if (clear_req) begin
                mq.delete();
                m_commit = 0; m_gvalid = 0; m_gval = 0; m_idle = 0;
            end else if (m_commit) begin
                if (guess_ack) begin
                    mq.delete();
                    m_commit = 0; m_gvalid = 0; m_gval = 0;
                end
            end else if (mq.size() > 0) begin
                if (m_evt) begin
                    m_idle = 0;
                    if (m_k < 10) begin
                        if (mq.size() < DIGITS) mq.push_back(m_k);
                    end else if (m_k == 11) begin
                        void'(mq.pop_back());
                    end else begin
                        m_gval = 0;
                        foreach (mq[i]) m_gval = m_gval * 10 + mq[i];
                        m_gvalid = 1;
                        m_commit = 1;
                    end
                end else if (m_idle == TO_CYC - 1) begin
                    mq.delete();
                    m_idle = 0;
                    m_tout = 1;
                end else begin
                    m_idle++;
                end
            end else if (m_evt && m_k < 10) begin
                mq.push_back(m_k);
                m_idle = 0;
            end
        end
    end

    function automatic logic [19:0] m_exp();
        logic [7:0] b;
        b = '0;
        foreach (mq[i]) b = (b << 4) | 8'(mq[i]);
        return {b, 2'(mq.size()), 7'(m_gval), m_gvalid, (m_commit || mq.size() > 0), m_tout};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {digit_bcd, digit_cnt, guess_val, guess_valid, entry_busy, timeout};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input int k, input int hold);
        scan_code = 12'(1) << k;
        scan_valid = 1'b1;
        repeat (hold) tick();
        scan_valid = 1'b0;
        scan_code = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_vec() !== 20'h0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
        else passes++;
        rst = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== m_exp()) $display("FAIL reset_model: got %h want %h", dut_vec(), m_exp());
        else passes++;
    endtask

    task automatic test_commit();
        press(4, 2);
        press(2, 2);
        checks++;
        if (digit_bcd !== 8'h42 || digit_cnt !== 2'd2)
            $display("FAIL entry_42: got bcd %h cnt %0d want 42/2", digit_bcd, digit_cnt);
        else passes++;
        press(10, 2);
        repeat (5) tick();
        checks++;
        if (guess_valid !== 1'b1 || guess_val !== 7'd42 || entry_busy !== 1'b1)
            $display("FAIL commit_42: got v %b val %0d busy %b want 1/42/1",
                     guess_valid, guess_val, entry_busy);
        else passes++;
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
        checks++;
        if (dut_vec() !== 20'h0) $display("FAIL ack_clear: got %h want 0", dut_vec());
        else passes++;
    endtask

    task automatic test_backspace();
        press(7, 1);
        press(3, 1);
        press(9, 1);
        checks++;
        if (digit_bcd !== 8'h73 || digit_cnt !== 2'd2)
            $display("FAIL third_digit_drop: got bcd %h cnt %0d want 73/2", digit_bcd, digit_cnt);
        else passes++;
        press(11, 1);
        checks++;
        if (digit_bcd !== 8'h07 || digit_cnt !== 2'd1)
            $display("FAIL backspace_1: got bcd %h cnt %0d want 07/1", digit_bcd, digit_cnt);
        else passes++;
        press(11, 1);
        checks++;
        if (digit_cnt !== 2'd0 || entry_busy !== 1'b0)
            $display("FAIL backspace_idle: got cnt %0d busy %b want 0/0", digit_cnt, entry_busy);
        else passes++;
        press(10, 1);
        checks++;
        if (guess_valid !== 1'b0 || entry_busy !== 1'b0)
            $display("FAIL star_in_idle: got v %b busy %b want 0/0", guess_valid, entry_busy);
        else passes++;
    endtask

    task automatic test_hold();
        int pulses = 0;
        int bad = 0;
        scan_code = 12'(1) << 5;
        scan_valid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (timeout) pulses++;
            if (dut_vec() !== m_exp()) bad++;
        end
        scan_valid = 1'b0;
        scan_code = '0;
        tick();
        checks++;
        if (pulses != 1 || bad != 0 || entry_busy !== 1'b0)
            $display("FAIL hold_one_event: got pulses %0d bad %0d busy %b want 1/0/0",
                     pulses, bad, entry_busy);
        else passes++;
        scan_code = 12'h003;
        scan_valid = 1'b1;
        repeat (3) tick();
        scan_valid = 1'b0;
        scan_code = '0;
        tick();
        checks++;
        if (dut_vec() !== 20'h0) $display("FAIL multihot_idle: got %h want 0", dut_vec());
        else passes++;
        press(8, 1);
        scan_code = 12'h003;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
        scan_code = '0;
        tick();
        checks++;
        if (digit_bcd !== 8'h08 || digit_cnt !== 2'd1)
            $display("FAIL multihot_entry: got bcd %h cnt %0d want 08/1", digit_bcd, digit_cnt);
        else passes++;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int bad = 0;
        press(6, 1);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (timeout) pulses++;
            if (dut_vec() !== m_exp()) bad++;
        end
        checks++;
        if (pulses != 1 || bad != 0 || digit_bcd !== 8'h00 || entry_busy !== 1'b0)
            $display("FAIL timeout_once: got pulses %0d bad %0d bcd %h busy %b want 1/0/00/0",
                     pulses, bad, digit_bcd, entry_busy);
        else passes++;
        // Second key lands exactly on the expiry cycle; the key must win.
        pulses = 0;
        press(6, 1);
        repeat (14) begin
            tick();
            if (timeout) pulses++;
        end
        scan_code = 12'(1) << 1;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
        scan_code = '0;
        repeat (3) begin
            tick();
            if (timeout) pulses++;
        end
        checks++;
        if (pulses != 0 || digit_bcd !== 8'h61 || digit_cnt !== 2'd2)
            $display("FAIL key_beats_timeout: got pulses %0d bcd %h cnt %0d want 0/61/2",
                     pulses, digit_bcd, digit_cnt);
        else passes++;
        repeat (20) tick();
        checks++;
        if (dut_vec() !== m_exp()) $display("FAIL timeout_model: got %h want %h", dut_vec(), m_exp());
        else passes++;
    endtask

    task automatic test_commit_ignore();
        press(1, 1);
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
        checks++;
        if (digit_bcd !== 8'h01 || entry_busy !== 1'b1 || guess_valid !== 1'b0)
            $display("FAIL ack_outside_commit: got bcd %h busy %b v %b want 01/1/0",
                     digit_bcd, entry_busy, guess_valid);
        else passes++;
        press(2, 1);
        press(10, 1);
        press(3, 1);
        checks++;
        if (digit_bcd !== 8'h12 || digit_cnt !== 2'd2 || guess_val !== 7'd12 || guess_valid !== 1'b1)
            $display("FAIL commit_frozen: got bcd %h cnt %0d val %0d v %b want 12/2/12/1",
                     digit_bcd, digit_cnt, guess_val, guess_valid);
        else passes++;
        clear_req = 1'b1;
        guess_ack = 1'b1;
        tick();
        clear_req = 1'b0;
        guess_ack = 1'b0;
        checks++;
        if (dut_vec() !== 20'h0) $display("FAIL clear_with_ack: got %h want 0", dut_vec());
        else passes++;
    endtask

    task automatic test_async_reset();
        press(9, 1);
        checks++;
        if (digit_bcd !== 8'h09) $display("FAIL pre_reset_entry: got %h want 09", digit_bcd);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 20'h0) $display("FAIL async_reset: got %h want 0", dut_vec());
        else passes++;
        tick();
        rst = 1'b1;
        tick();
        press(5, 1);
        checks++;
        if (digit_bcd !== 8'h05 || digit_cnt !== 2'd1 || entry_busy !== 1'b1)
            $display("FAIL post_reset_digit: got bcd %h cnt %0d busy %b want 05/1/1",
                     digit_bcd, digit_cnt, entry_busy);
        else passes++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 1) == 0) scan_valid = ~scan_valid;
            if ($urandom_range(0, 9) < 8) scan_code = 12'(1) << $urandom_range(0, 11);
            else scan_code = 12'($urandom);
            clear_req = ($urandom_range(0, 99) < 2);
            guess_ack = ($urandom_range(0, 99) < 15);
            tick();
            checks++;
            if (dut_vec() !== m_exp())
                $display("FAIL random_cycle_%0d: got %h want %h", c, dut_vec(), m_exp());
            else passes++;
        end
        scan_valid = 1'b0;
        clear_req = 1'b0;
        guess_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit();
        test_backspace();
        test_hold();
        test_timeout();
        test_commit_ignore();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
